// File: rtl/tron_pkg.sv
// Shared types and constants for the tron plot path: coordinate widths, arena bounds,
// scheduler/border-walker encodings and requester IDs.
package tron_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  localparam int unsigned BX0_DEF  = 10;
  localparam int unsigned BX1_DEF  = 149;
  localparam int unsigned BY0_DEF  = 17;
  localparam int unsigned BY1_DEF  = 108;
  localparam int unsigned XMAX_DEF = 159;
  localparam int unsigned YMAX_DEF = 119;

  localparam logic [C_W-1:0] BORDER_COLOUR_DEF = 3'b111;

  typedef enum logic {StServe, StBorder} sched_state_e;

  typedef enum logic [1:0] {PhTop, PhBottom, PhLeft, PhRight} border_phase_e;

  typedef enum logic {ReqP1, ReqP2} req_id_e;

  function automatic logic in_arena(logic [X_W-1:0] x, logic [Y_W-1:0] y,
                                    int unsigned xmax, int unsigned ymax);
    return (32'(x) <= xmax) && (32'(y) <= ymax);
  endfunction

endpackage

// File: rtl/border_walker.sv
// Walks the arena perimeter one pixel per cycle: top row, bottom row, left column, right
// column. Pixel 0 is emitted by the scheduler itself, so start loads pixel 1.
module border_walker
  import tron_pkg::*;
#(
  parameter int unsigned BX0 = BX0_DEF,
  parameter int unsigned BX1 = BX1_DEF,
  parameter int unsigned BY0 = BY0_DEF,
  parameter int unsigned BY1 = BY1_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           valid_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] XLo     = X_W'(BX0);
  localparam logic [X_W-1:0] XHi     = X_W'(BX1);
  localparam logic [Y_W-1:0] YLo     = Y_W'(BY0);
  localparam logic [Y_W-1:0] YHi     = Y_W'(BY1);
  localparam logic [Y_W-1:0] YSideLo = Y_W'(BY0 + 1);
  localparam logic [Y_W-1:0] YSideHi = Y_W'(BY1 - 1);

  border_phase_e  phase_q, phase_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           active_q, active_d;

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign valid_o = active_q;
  assign last_o  = active_q && (phase_q == PhRight) && (y_q == YSideHi);

  always_comb begin
    phase_d  = phase_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    if (start_i) begin
      phase_d  = PhTop;
      x_d      = XLo + X_W'(1);
      y_d      = YLo;
      active_d = 1'b1;
    end else if (active_q) begin
      unique case (phase_q)
        PhTop: begin
          if (x_q == XHi) begin
            phase_d = PhBottom;
            x_d     = XLo;
            y_d     = YHi;
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
        PhBottom: begin
          if (x_q == XHi) begin
            phase_d = PhLeft;
            x_d     = XLo;
            y_d     = YSideLo;
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
        PhLeft: begin
          if (y_q == YSideHi) begin
            phase_d = PhRight;
            x_d     = XHi;
            y_d     = YSideLo;
          end else begin
            y_d = y_q + Y_W'(1);
          end
        end
        PhRight: begin
          if (y_q == YSideHi) begin
            active_d = 1'b0;
          end else begin
            y_d = y_q + Y_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q  <= PhTop;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Owns the VGA pixel-write port: round-robin service of two tron requesters, with a
// border-draw mode that stalls players while the perimeter is painted.
module vga_plot_scheduler
  import tron_pkg::*;
#(
  parameter int unsigned     BX0           = BX0_DEF,
  parameter int unsigned     BX1           = BX1_DEF,
  parameter int unsigned     BY0           = BY0_DEF,
  parameter int unsigned     BY1           = BY1_DEF,
  parameter logic [C_W-1:0]  BORDER_COLOUR = BORDER_COLOUR_DEF,
  parameter int unsigned     XMAX          = XMAX_DEF,
  parameter int unsigned     YMAX          = YMAX_DEF
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           border_start_i,
  output logic           border_busy_o,
  output logic           border_done_o,
  input  logic           p1_req_i,
  input  logic [X_W-1:0] p1_x_i,
  input  logic [Y_W-1:0] p1_y_i,
  input  logic [C_W-1:0] p1_colour_i,
  output logic           p1_ack_o,
  input  logic           p2_req_i,
  input  logic [X_W-1:0] p2_x_i,
  input  logic [Y_W-1:0] p2_y_i,
  input  logic [C_W-1:0] p2_colour_i,
  output logic           p2_ack_o,
  output logic           plot_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [C_W-1:0] colour_o,
  output logic           oob_err_o
);

  sched_state_e   state_q, state_d;
  req_id_e        last_q, last_d;
  logic           plot_q, plot_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic           p1_ack_q, p1_ack_d;
  logic           p2_ack_q, p2_ack_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           oob_q, oob_d;

  logic           walk_start;
  logic [X_W-1:0] walk_x;
  logic [Y_W-1:0] walk_y;
  logic           walk_valid;
  logic           walk_last;

  border_walker #(
    .BX0 (BX0),
    .BX1 (BX1),
    .BY0 (BY0),
    .BY1 (BY1)
  ) u_walker (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .start_i (walk_start),
    .x_o     (walk_x),
    .y_o     (walk_y),
    .valid_o (walk_valid),
    .last_o  (walk_last)
  );

  // A requester whose ack is currently high is still dropping req; don't grant it again.
  logic           elig1, elig2;
  req_id_e        gnt_id;
  logic [X_W-1:0] gnt_x;
  logic [Y_W-1:0] gnt_y;
  logic [C_W-1:0] gnt_c;

  assign elig1 = p1_req_i & ~p1_ack_q;
  assign elig2 = p2_req_i & ~p2_ack_q;

  always_comb begin
    if (elig1 && elig2) begin
      gnt_id = (last_q == ReqP2) ? ReqP1 : ReqP2;
    end else begin
      gnt_id = elig1 ? ReqP1 : ReqP2;
    end
    gnt_x = (gnt_id == ReqP2) ? p2_x_i : p1_x_i;
    gnt_y = (gnt_id == ReqP2) ? p2_y_i : p1_y_i;
    gnt_c = (gnt_id == ReqP2) ? p2_colour_i : p1_colour_i;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    plot_d     = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    p1_ack_d   = 1'b0;
    p2_ack_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    oob_d      = oob_q;
    walk_start = 1'b0;
    unique case (state_q)
      StServe: begin
        if (border_start_i) begin
          // First perimeter pixel goes out directly; the walker resumes from pixel 1.
          state_d    = StBorder;
          walk_start = 1'b1;
          plot_d     = 1'b1;
          x_d        = X_W'(BX0);
          y_d        = Y_W'(BY0);
          colour_d   = BORDER_COLOUR;
          busy_d     = 1'b1;
        end else if (elig1 || elig2) begin
          last_d   = gnt_id;
          p1_ack_d = (gnt_id == ReqP1);
          p2_ack_d = (gnt_id == ReqP2);
          if (in_arena(gnt_x, gnt_y, XMAX, YMAX)) begin
            plot_d   = 1'b1;
            x_d      = gnt_x;
            y_d      = gnt_y;
            colour_d = gnt_c;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      StBorder: begin
        if (walk_valid) begin
          plot_d   = 1'b1;
          x_d      = walk_x;
          y_d      = walk_y;
          colour_d = BORDER_COLOUR;
          busy_d   = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = StServe;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StServe;
      last_q   <= ReqP2;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      p1_ack_q <= 1'b0;
      p2_ack_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      p1_ack_q <= p1_ack_d;
      p2_ack_q <= p2_ack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
    end
  end

  assign plot_o        = plot_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign colour_o      = colour_q;
  assign p1_ack_o      = p1_ack_q;
  assign p2_ack_o      = p2_ack_q;
  assign border_busy_o = busy_q;
  assign border_done_o = done_q;
  assign oob_err_o     = oob_q;

  // walk_last is implied by walk_valid dropping; kept for observability.
  logic unused_walk_last;
  assign unused_walk_last = walk_last;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Bench for vga_plot_scheduler: directed scenarios plus random requester traffic, all
// checked every cycle against a perimeter list and a transaction-level arbiter model.
module tb_vga_plot_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       border_start = 1'b0;
  logic       border_busy, border_done;
  logic       p1_req = 1'b0, p2_req = 1'b0;
  logic [7:0] p1_x = '0, p2_x = '0;
  logic [6:0] p1_y = '0, p2_y = '0;
  logic [2:0] p1_colour = '0, p2_colour = '0;
  logic       p1_ack, p2_ack;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       oob_err;

  vga_plot_scheduler dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .border_start_i (border_start),
    .border_busy_o  (border_busy),
    .border_done_o  (border_done),
    .p1_req_i       (p1_req),
    .p1_x_i         (p1_x),
    .p1_y_i         (p1_y),
    .p1_colour_i    (p1_colour),
    .p1_ack_o       (p1_ack),
    .p2_req_i       (p2_req),
    .p2_x_i         (p2_x),
    .p2_y_i         (p2_y),
    .p2_colour_i    (p2_colour),
    .p2_ack_o       (p2_ack),
    .plot_o         (plot),
    .x_o            (x),
    .y_o            (y),
    .colour_o       (colour),
    .oob_err_o      (oob_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  logic       e_plot, e_a1, e_a2, e_busy, e_done, e_oob;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_c;
  bit         m_border;
  int         m_idx;
  bit         m_last_p2;
  logic [7:0] bx_q[$];
  logic [6:0] by_q[$];

  function automatic void build_border();
    for (int i = 10; i <= 149; i++) begin bx_q.push_back(8'(i)); by_q.push_back(7'd17); end
    for (int i = 10; i <= 149; i++) begin bx_q.push_back(8'(i)); by_q.push_back(7'd108); end
    for (int i = 18; i <= 107; i++) begin bx_q.push_back(8'd10); by_q.push_back(7'(i)); end
    for (int i = 18; i <= 107; i++) begin bx_q.push_back(8'd149); by_q.push_back(7'(i)); end
  endfunction

  function automatic void model_reset();
    e_plot = 0; e_a1 = 0; e_a2 = 0; e_busy = 0; e_done = 0; e_oob = 0;
    e_x = '0; e_y = '0; e_c = '0;
    m_border = 0; m_idx = 0; m_last_p2 = 1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic       a1, a2, el1, el2, pick2;
    logic [7:0] gx;
    logic [6:0] gy;
    logic [2:0] gc;
    a1 = e_a1; a2 = e_a2;
    e_a1 = 0; e_a2 = 0; e_plot = 0; e_busy = 0; e_done = 0;
    if (m_border) begin
      if (m_idx < bx_q.size()) begin
        e_plot = 1; e_busy = 1; e_c = 3'b111;
        e_x = bx_q[m_idx]; e_y = by_q[m_idx];
        m_idx++;
      end else begin
        e_done = 1;
        m_border = 0;
      end
    end else if (border_start) begin
      m_border = 1;
      e_plot = 1; e_busy = 1; e_c = 3'b111;
      e_x = bx_q[0]; e_y = by_q[0];
      m_idx = 1;
    end else begin
      el1 = p1_req && !a1;
      el2 = p2_req && !a2;
      if (el1 || el2) begin
        pick2 = (el1 && el2) ? !m_last_p2 : el2;
        gx = pick2 ? p2_x : p1_x;
        gy = pick2 ? p2_y : p1_y;
        gc = pick2 ? p2_colour : p1_colour;
        m_last_p2 = pick2;
        if (pick2) e_a2 = 1; else e_a1 = 1;
        if (gx > 8'd159 || gy > 7'd119) begin
          e_oob = 1;
        end else begin
          e_plot = 1; e_x = gx; e_y = gy; e_c = gc;
        end
      end
    end
  endfunction

  function automatic logic [23:0] dut_vec();
    return {plot, x, y, colour, p1_ack, p2_ack, border_busy, border_done, oob_err};
  endfunction

  function automatic logic [23:0] exp_vec();
    return {e_plot, e_x, e_y, e_c, e_a1, e_a2, e_busy, e_done, e_oob};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", 32'(dut_vec()), 32'(exp_vec()));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drop_acked();
    if (e_a1) p1_req = 1'b0;
    if (e_a2) p2_req = 1'b0;
  endtask

  task automatic new_req(output logic [7:0] nx, output logic [6:0] ny, output logic [2:0] nc);
    nx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
    ny = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
    nc = 3'($urandom_range(0, 7));
  endtask

  int          busy_cnt, plot_cnt, done_cnt;
  int          chk_idx[4] = '{0, 140, 280, 459};
  logic [14:0] chk_xy[4]  = '{{8'd10, 7'd17}, {8'd10, 7'd108}, {8'd10, 7'd18}, {8'd149, 7'd107}};

  initial begin
    build_border();
    model_reset();
    @(negedge clk);
    check("reset_state", 32'(dut_vec()), 32'(exp_vec()));
    reset = 1'b0;

    // Single P1 request, dropped after ack
    p1_x = 8'd25; p1_y = 7'd25; p1_colour = 3'b100; p1_req = 1'b1;
    tick("p1_single");
    check("p1_single_plot", {x, y, colour, plot}, {8'd25, 7'd25, 3'd4, 1'b1});
    drop_acked();
    tick("p1_dropped");
    tick("p1_idle");

    // Both requesters held continuously: alternate, P1 first after reset
    do_reset();
    p1_x = 8'd25; p1_y = 7'd25; p1_colour = 3'b001; p1_req = 1'b1;
    p2_x = 8'd75; p2_y = 7'd75; p2_colour = 3'b010; p2_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick("alternate");
      check("alt_order", {p1_ack, p2_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    p1_req = 1'b0; p2_req = 1'b0;
    tick("alt_drain");

    // Border with P2 pending at the same edge
    p2_x = 8'd40; p2_y = 7'd40; p2_colour = 3'b011; p2_req = 1'b1;
    border_start = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 460; i++) begin
      tick("border");
      border_start = 1'b0;
      busy_cnt += int'(border_busy);
      for (int k = 0; k < 4; k++)
        if (i == chk_idx[k]) check("border_corner", {x, y}, chk_xy[k]);
    end
    tick("border_done");
    check("done_pulse", border_done, 1'b1);
    check("busy_cycles", busy_cnt, 460);
    tick("p2_after_done");
    check("p2_ack_late", p2_ack, 1'b1);
    drop_acked();
    tick("p2_drain");

    // Out-of-range request: ack without plot, sticky error
    p1_x = 8'd160; p1_y = 7'd5; p1_colour = 3'b001; p1_req = 1'b1;
    tick("oob");
    drop_acked();
    p2_x = 8'd30; p2_y = 7'd30; p2_colour = 3'b101; p2_req = 1'b1;
    tick("oob_then_legal");
    drop_acked();
    tick("oob_sticky");
    check("oob_held", oob_err, 1'b1);

    // Reset in the middle of a border draw
    border_start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick("border_pre_reset");
      border_start = 1'b0;
    end
    do_reset();
    p1_x = 8'd50; p1_y = 7'd60; p1_colour = 3'b010; p1_req = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick("after_abort");
      drop_acked();
      done_cnt += int'(border_done);
    end
    check("no_done_after_abort", done_cnt, 0);

    // Re-pulsed border_start mid-draw is ignored
    plot_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 470; i++) begin
      border_start = (i == 0 || i == 100);
      tick("restart_ignored");
      plot_cnt += int'(plot);
      done_cnt += int'(border_done);
    end
    border_start = 1'b0;
    check("restart_plots", plot_cnt, 460);
    check("restart_done", done_cnt, 1);

    // Random requester traffic with occasional border draws
    for (int i = 0; i < 600; i++) begin
      border_start = ($urandom_range(0, 149) == 0);
      tick("random");
      if (p1_req && e_a1) begin
        p1_req = ($urandom_range(0, 1) == 1);
        if (p1_req) new_req(p1_x, p1_y, p1_colour);
      end else if (p1_req && $urandom_range(0, 15) == 0) begin
        p1_req = 1'b0;
      end else if (!p1_req && $urandom_range(0, 1) == 1) begin
        p1_req = 1'b1;
        new_req(p1_x, p1_y, p1_colour);
      end
      if (p2_req && e_a2) begin
        p2_req = ($urandom_range(0, 1) == 1);
        if (p2_req) new_req(p2_x, p2_y, p2_colour);
      end else if (p2_req && $urandom_range(0, 15) == 0) begin
        p2_req = 1'b0;
      end else if (!p2_req && $urandom_range(0, 1) == 1) begin
        p2_req = 1'b1;
        new_req(p2_x, p2_y, p2_colour);
      end
    end
    border_start = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
    for (int i = 0; i < 470; i++) tick("random_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_plot_scheduler.md
Name: vga_plot_scheduler

Overview:
- Owns the single pixel-write port of the VGA adapter: x, y, colour and plot.
- Serves two tron requesters (P1, P2) through a req/ack handshake with round-robin fairness.
- Contains a border-draw engine that, on command, walks the arena perimeter at one pixel per cycle. While it runs, player plots are stalled.
- Replaces the ad-hoc counter/switch mux in the top level. Sits between the tron datapaths/controls and vga_adapter.

Parameters:
- BX0, 10, border left column
- BX1, 149, border right column
- BY0, 17, border top row
- BY1, 108, border bottom row
- BORDER_COLOUR, 3'b111, colour of border pixels
- XMAX, 159, largest legal x
- YMAX, 119, largest legal y

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- border_start  in  1  one-cycle pulse; starts a border draw
- border_busy  out  1  high while the border engine owns the port
- border_done  out  1  one-cycle pulse in the cycle after the last border pixel
- p1_req  in  1  P1 pixel request; held with data until p1_ack
- p1_x  in  8  P1 x coordinate
- p1_y  in  7  P1 y coordinate
- p1_colour  in  3  P1 colour
- p1_ack  out  1  one-cycle acknowledge to P1
- p2_req, p2_x, p2_y, p2_colour, p2_ack  as for P1
- plot  out  1  write strobe to vga_adapter
- x  out  8  pixel x to vga_adapter
- y  out  7  pixel y to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- oob_err  out  1  sticky; set by any out-of-range request

Behaviour:
- Reset (async, active-high):
  - plot, p1_ack, p2_ack, border_busy, border_done, oob_err = 0; x = 0, y = 0, colour = 0.
  - FSM enters SERVE; last_grant = P2, so P1 wins the first contention.
  - Reset mid-border aborts the draw immediately; no border_done is issued.
- All outputs are registered. At most one plot per cycle.
- FSM has two states, SERVE and BORDER.
- SERVE eligibility: at rising edge N a requester is eligible if its req = 1 and its ack is not high during cycle N. This prevents a double grant while the requester is dropping req.
- SERVE arbitration:
  - One eligible requester: it is granted.
  - Both eligible: the one that is not last_grant is granted; last_grant is then updated.
- Grant latency: in cycle N+1 the winner's ack = 1; plot = 1 with its x, y and colour; all other ack = 0.
- Throughput: with both requesters continuously requesting, grants alternate every cycle. A single requester is granted at most every 2nd cycle.
- Withdrawal: req may drop before ack; no grant is issued and no error is raised.
- Out of range (x > XMAX or y > YMAX): ack is still given, plot = 0, oob_err is set. oob_err clears only on reset.
- Entering BORDER: border_start = 1 while in SERVE causes BORDER from the next cycle. border_start wins over player requests sampled at the same edge; those requests receive no ack and are retried later.
- border_start while in BORDER is ignored.
- BORDER sequence, one plot per cycle with colour = BORDER_COLOUR, no acks:
  - phase TOP: y = BY0, x = BX0..BX1
  - phase BOTTOM: y = BY1, x = BX0..BX1
  - phase LEFT: x = BX0, y = BY0+1..BY1-1
  - phase RIGHT: x = BX1, y = BY0+1..BY1-1
  - Total = 2*(BX1-BX0+1) + 2*(BY1-BY0-1) = 460 pixels with default parameters.
- border_busy is high for exactly those 460 plot cycles.
- Leaving BORDER: the cycle after the last pixel, plot = 0, border_busy = 0 and border_done = 1; the FSM returns to SERVE. Arbitration resumes at that edge; the earliest player ack is in the following cycle.
- Idle cycles: when there is no plot, plot = 0 and x, y, colour hold their last values.

Decomposition:
- Shared package tron_pkg holds:
  - coordinate widths (X_W = 8, Y_W = 7, C_W = 3)
  - default arena bounds and XMAX/YMAX
  - FSM state and border-phase encodings
  - requester IDs
- One natural sub-module: border_walker. It contains the phase and x/y counters and emits pixel, valid and last. The scheduler contains the FSM, the round-robin arbiter and the output registers.

Test Plan:
- Reset, then p1_req = 1 with (25,25,3'b100) held -> cycle 1: plot = 1, x = 25, y = 25, colour = 4, p1_ack = 1; P1 drops req and no second plot follows.
- p1_req and p2_req held continuously at the same edge, P1 at (25,25), P2 at (75,75) -> plots alternate P1, P2, P1, P2 every cycle; acks match; P1 is first after reset.
- border_start pulse with p2_req pending at the same edge -> 460 consecutive plots with colour 7:
  - first (10,17); pixel 141 = (10,108); pixel 281 = (10,18); last (149,107)
  - border_busy high for 460 cycles, border_done one cycle later
  - p2_ack only after border_done
- p1 request at x = 160, y = 5 -> p1_ack = 1, plot = 0, oob_err = 1 and it stays set through subsequent legal plots.
- Assert reset at border pixel 200 -> all outputs 0 immediately; after release, p1_req is served normally and border_done never pulses.
- border_start re-pulsed at pixel 100 of a draw -> still exactly 460 plots and a single border_done.
